aes_inv_key_schedule: RTL and testbench
=======================================

Name: aes_inv_key_schedule

Overview:
Iterative AES-128 key schedule. It expands a cipher key one round per cycle and delivers round keys over a valid/ready handshake to the round datapath.
- Encrypt: keys are emitted in forward order, round 0..10.
- Decrypt: the block first runs the schedule forward to round 10, then walks the inverse recurrence and emits keys in reverse order, round 10..0.
- Sits between the key register and the round port in the iterative core.

Parameters:
NR, 10, number of rounds (AES-128 only; other values unsupported).
RCON_LAST, 8'h36, Rcon of round NR; seeds the backward Rcon.

Ports:
Clk  input  1  clock, rising edge.
Rst_n  input  1  asynchronous active-low reset.
Start  input  1  request a new schedule; sampled only when Busy=0.
Encrypt  input  1  direction, sampled with Start (1 = forward order, 0 = reverse order).
Key  input  `AES_BLOCK_SIZE  cipher key, sampled with Start.
Round_key  output  `AES_BLOCK_SIZE  current round key.
Round_key_valid  output  1  Round_key is valid.
Round_key_ready  input  1  consumer accepts Round_key.
Round_index  output  4  round number of Round_key (0..10).
Last  output  1  Round_key is the final key of the sequence.
Busy  output  1  schedule in progress.

Behaviour:
- Reset (async, Rst_n=0): state IDLE; Round_key=0, Round_key_valid=0, Round_index=0, Last=0, Busy=0; internal Rcon=8'h01; counter=0.
- States: IDLE, PRECOMP, EMIT.
- IDLE:
  - Start=1 loads Key into the key register and captures Encrypt; Busy rises the next cycle.
  - Encrypt=1 -> EMIT with Round_index=0 and Rcon=8'h01.
  - Encrypt=0 -> PRECOMP with counter=0.
- PRECOMP:
  - One forward expansion step per cycle; Rcon advances by xtime (r<<1, ^8'h1B on carry).
  - After exactly NR steps (counter==NR-1) -> EMIT with Round_index=NR and Rcon=RCON_LAST.
  - Round_key_valid=0 throughout.
- EMIT:
  - Round_key_valid=1; Round_key, Round_index and Last stay stable while Round_key_ready=0.
  - On a handshake (valid and ready), the next key is loaded the following cycle.
  - Forward step: w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,24'h0}; then wi' = wi ^ w(i-1)' for i=1..3; Round_index+1; Rcon = xtime(Rcon).
  - Backward step: wi = wi' ^ w(i-1)' for i=3..1; w0 = w0' ^ SubWord(RotWord(w3)) ^ {Rcon,24'h0}, using the recovered w3; Round_index-1; Rcon = (r>>1) ^ (r[0] ? 8'h8D : 0).
- Last=1 when Round_index==NR (encrypt) or Round_index==0 (decrypt).
- A handshake with Last=1 -> IDLE the next cycle; Round_key_valid=0, Busy=0, Round_key holds its final value.
- Start while Busy=1, including the cycle of the final handshake: ignored, no queueing.
- Latency from Start accepted at cycle T:
  - Encrypt: first valid at T+1.
  - Decrypt: first valid at T+1+NR.
- Back-to-back handshakes produce 11 keys in 11 consecutive cycles.
- Reset asserted mid-operation aborts immediately to the reset values; no partial output survives.
- Word order: w0 = Round_key[127:96], big-endian byte order per FIPS-197.

Optional Feature:
AES_KEY_CACHE_EN
- Defined:
  - Adds a 128-bit cached cipher key, a 128-bit cached round-NR key and a cache-valid flag.
  - Decrypt Start with Key equal to the cached key and cache-valid=1 skips PRECOMP: EMIT at T+1 with the cached round-NR key.
  - A PRECOMP completion updates the cache.
  - Reset clears cache-valid.
- Not defined: decrypt always runs PRECOMP; no extra registers.

Decomposition:
- Package aes_pkg holds:
  - state enum (IDLE, PRECOMP, EMIT)
  - AES_NR, RCON_FIRST=8'h01, RCON_LAST=8'h36
  - xtime and inverse-xtime functions
  - the 4-byte word typedef
- One sub-module, aes_sub_word: 4 parallel forward S-boxes, combinational. The schedule only ever needs the forward S-box, both forward and backward.

Test Plan:
- Encrypt, Key=2b7e151628aed2a6abf7158809cf4f3c, Round_key_ready held at 1 -> valid at T+1. Round 1 = a0fafe1788542cb123a339392a6c7605. Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with Last=1; Busy falls the next cycle.
- Decrypt, same Key, ready=1 -> no valid for 10 cycles. First key at T+11 = d014f9a8...0ca6, Round_index=10. Final key = 2b7e1516...09cf4f3c, Round_index=0, Last=1.
- Ready toggled randomly during decrypt -> Round_key stable while stalled; sequence identical to the previous scenario.
- Start pulsed in the cycle of the final handshake and while in PRECOMP -> ignored; output sequence unchanged.
- Rst_n dropped during EMIT at round 5 -> all outputs 0 immediately. A new encrypt Start after release produces round 0 correctly.
- With AES_KEY_CACHE_EN defined, two consecutive decrypts with the same key -> the second shows valid at T+1 with d014f9a8...0ca6. A different key -> full 10-cycle PRECOMP.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and GF(2^8) Rcon helpers.
// Also provides the `AES_BLOCK_SIZE width used on the schedule's key ports.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

package aes_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRECOMP = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam int         AES_NR     = 10;
  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

  // Divide by x; 8'h8D is 8'h1B shifted right with the dropped x^8 term folded in.
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return (r >> 1) ^ (r[0] ? 8'h8D : 8'h00);
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel forward AES S-boxes applied to one 32-bit word; purely combinational.
// Shared by the forward and inverse key recurrences, which both use the forward S-box.
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t word,
  output word_t sub
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sub = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 key schedule: one round key per handshake, forward (0..NR) or reverse (NR..0).
// Encrypt keys valid 1 cycle after Start, decrypt after NR+1; keys hold while Round_key_ready=0. Optional AES_KEY_CACHE_EN.
module aes_inv_key_schedule #(
  parameter int         NR        = aes_pkg::AES_NR,
  parameter logic [7:0] RCON_LAST = aes_pkg::RCON_LAST
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Start,
  input  logic                       Encrypt,
  input  logic [`AES_BLOCK_SIZE-1:0] Key,
  output logic [`AES_BLOCK_SIZE-1:0] Round_key,
  output logic                       Round_key_valid,
  input  logic                       Round_key_ready,
  output logic [3:0]                 Round_index,
  output logic                       Last,
  output logic                       Busy
);

  import aes_pkg::*;

  state_t                     state, state_d;
  logic [`AES_BLOCK_SIZE-1:0] key_q, key_d;
  logic [7:0]                 rcon, rcon_d;
  logic [3:0]                 round_idx, idx_d;
  logic [3:0]                 cnt, cnt_d;
  logic                       enc_q, enc_d;

`ifdef AES_KEY_CACHE_EN
  logic [`AES_BLOCK_SIZE-1:0] cache_key, ckey_d;
  logic [`AES_BLOCK_SIZE-1:0] cache_rk, crk_d;
  logic                       cache_vld, cvld_d;
`endif

  word_t w0, w1, w2, w3;
  word_t b1, b2, b3;
  word_t sw_in, sw_out, mix0;
  logic  backward;
  logic [`AES_BLOCK_SIZE-1:0] fwd_key, bwd_key;

  assign {w0, w1, w2, w3} = key_q;
  assign backward = (state == EMIT) && !enc_q;

  // Inverse step recovers w3..w1 first; the recovered w3 feeds the S-box for w0.
  assign b3 = w3 ^ w2;
  assign b2 = w2 ^ w1;
  assign b1 = w1 ^ w0;
  assign sw_in = rot_word(backward ? b3 : w3);

  aes_sub_word u_sub_word (
    .word (sw_in),
    .sub  (sw_out)
  );

  assign mix0    = w0 ^ sw_out ^ {rcon, 24'h0};
  assign fwd_key = {mix0, w1 ^ mix0, w2 ^ w1 ^ mix0, w3 ^ w2 ^ w1 ^ mix0};
  assign bwd_key = {mix0, b1, b2, b3};

  assign Round_key       = key_q;
  assign Round_key_valid = (state == EMIT);
  assign Round_index     = round_idx;
  assign Last            = Round_key_valid && (enc_q ? (round_idx == 4'(NR)) : (round_idx == 4'd0));
  assign Busy            = (state != IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      key_q     <= '0;
      rcon      <= RCON_FIRST;
      round_idx <= '0;
      cnt       <= '0;
      enc_q     <= 1'b0;
`ifdef AES_KEY_CACHE_EN
      cache_key <= '0;
      cache_rk  <= '0;
      cache_vld <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      key_q     <= key_d;
      rcon      <= rcon_d;
      round_idx <= idx_d;
      cnt       <= cnt_d;
      enc_q     <= enc_d;
`ifdef AES_KEY_CACHE_EN
      cache_key <= ckey_d;
      cache_rk  <= crk_d;
      cache_vld <= cvld_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    key_d   = key_q;
    rcon_d  = rcon;
    idx_d   = round_idx;
    cnt_d   = cnt;
    enc_d   = enc_q;
`ifdef AES_KEY_CACHE_EN
    ckey_d  = cache_key;
    crk_d   = cache_rk;
    cvld_d  = cache_vld;
`endif
    unique case (state)
      IDLE: begin
        if (Start) begin
          key_d  = Key;
          enc_d  = Encrypt;
          idx_d  = '0;
          cnt_d  = '0;
          rcon_d = RCON_FIRST;
          if (Encrypt) begin
            state_d = EMIT;
`ifdef AES_KEY_CACHE_EN
          end else if (cache_vld && (Key == cache_key)) begin
            state_d = EMIT;
            key_d   = cache_rk;
            idx_d   = 4'(NR);
            rcon_d  = RCON_LAST;
          end else begin
            // Cached key is replaced now; the entry becomes valid only when precompute completes.
            state_d = PRECOMP;
            ckey_d  = Key;
            cvld_d  = 1'b0;
          end
`else
          end else begin
            state_d = PRECOMP;
          end
`endif
        end
      end
      PRECOMP: begin
        key_d  = fwd_key;
        rcon_d = xtime(rcon);
        cnt_d  = cnt + 4'd1;
        if (cnt == 4'(NR - 1)) begin
          state_d = EMIT;
          idx_d   = 4'(NR);
          rcon_d  = RCON_LAST;
`ifdef AES_KEY_CACHE_EN
          crk_d   = fwd_key;
          cvld_d  = 1'b1;
`endif
        end
      end
      EMIT: begin
        if (Round_key_ready) begin
          if (Last) begin
            state_d = IDLE;
          end else if (enc_q) begin
            key_d  = fwd_key;
            idx_d  = round_idx + 4'd1;
            rcon_d = xtime(rcon);
          end else begin
            key_d  = bwd_key;
            idx_d  = round_idx - 4'd1;
            rcon_d = inv_xtime(rcon);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: FIPS-197 vectors plus random keys/ready against a word-expansion model.
// The model derives the S-box from GF(2^8) inversion and the affine map rather than a table.
module tb_aes_inv_key_schedule;

  logic         Clk;
  logic         Rst_n;
  logic         Start;
  logic         Encrypt;
  logic [127:0] Key;
  logic [127:0] Round_key;
  logic         Round_key_valid;
  logic         Round_key_ready;
  logic [3:0]   Round_index;
  logic         Last;
  logic         Busy;

  aes_inv_key_schedule dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .Start           (Start),
    .Encrypt         (Encrypt),
    .Key             (Key),
    .Round_key       (Round_key),
    .Round_key_valid (Round_key_valid),
    .Round_key_ready (Round_key_ready),
    .Round_index     (Round_index),
    .Last            (Last),
    .Busy            (Busy)
  );

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sb     [0:255];
  logic [127:0] exp_rk [0:10];

  logic [127:0] got_key [$];
  int           got_idx [$];
  bit           got_last[$];
  int           first_lat, last_hs_cyc, stall_bad;
  logic         busy_first, busy_after, valid_after;
  logic [127:0] key_after;
  bit           timed_out;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 KeyExpansion over 44 words, then grouped into 11 round keys.
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t  = t ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Number of collected entries disagreeing with the model for the given direction.
  function automatic int seq_errs(input bit enc);
    int e;
    int r;
    e = 0;
    if (got_key.size() != 11) return 100 + got_key.size();
    for (int j = 0; j < 11; j++) begin
      r = enc ? j : 10 - j;
      if (got_key[j] !== exp_rk[r] || got_idx[j] != r || got_last[j] != (j == 10)) e++;
    end
    return e;
  endfunction

  // Starts one schedule and records every handshaked key; optional ignored Start pulses.
  task automatic collect(input logic [127:0] k, input bit enc, input int ready_pct, input bit pulse);
    bit           prev_stall;
    bit           done;
    int           cyc;
    logic [127:0] pk;
    logic [3:0]   pi;
    logic         pl;
    got_key.delete();
    got_idx.delete();
    got_last.delete();
    first_lat = -1; last_hs_cyc = -1; stall_bad = 0; timed_out = 0;
    prev_stall = 0; done = 0; cyc = 0;
    pk = '0; pi = '0; pl = 1'b0;
    Start = 1'b1; Encrypt = enc; Key = k; Round_key_ready = 1'b0;
    tick();
    Start = 1'b0;
    while (!done) begin
      cyc++;
      if (cyc == 1) busy_first = Busy;
      if (cyc > 200) begin
        timed_out = 1;
        break;
      end
      if (prev_stall && (!Round_key_valid || Round_key !== pk || Round_index !== pi || Last !== pl))
        stall_bad++;
      Round_key_ready = ($urandom_range(0, 99) < ready_pct);
      Start = 1'b0;
      if (pulse && cyc == 3) begin
        Start = 1'b1; Encrypt = !enc; Key = ~k;
      end
      if (Round_key_valid) begin
        if (first_lat < 0) first_lat = cyc;
        if (Round_key_ready) begin
          got_key.push_back(Round_key);
          got_idx.push_back(int'(Round_index));
          got_last.push_back(Last);
          last_hs_cyc = cyc;
          if (Last) begin
            done = 1;
            if (pulse) begin
              Start = 1'b1; Encrypt = 1'b1; Key = ~k;
            end
          end
        end
      end
      prev_stall = Round_key_valid && !Round_key_ready;
      pk = Round_key; pi = Round_index; pl = Last;
      tick();
    end
    Start = 1'b0;
    Round_key_ready = 1'b0;
    busy_after  = Busy;
    valid_after = Round_key_valid;
    key_after   = Round_key;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Start = 1'b0; Encrypt = 1'b0; Key = '0; Round_key_ready = 1'b0;
    repeat (2) tick();
    n_tests++; if (Round_key !== 128'h0) begin n_fail++; $display("FAIL reset_key: got %h required 0", Round_key); end
    n_tests++; if (Round_key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", Round_key_valid); end
    n_tests++; if (Round_index !== 4'd0) begin n_fail++; $display("FAIL reset_index: got %0d required 0", Round_index); end
    n_tests++; if (Last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b required 0", Last); end
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", Busy); end
    Rst_n = 1'b1;
    repeat (2) tick();
    n_tests++; if (Busy !== 1'b0 || Round_key_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy %b valid %b required 0 0", Busy, Round_key_valid); end
  endtask

  task automatic test_encrypt_vector();
    int e;
    expand(FIPS_KEY);
    collect(FIPS_KEY, 1'b1, 100, 1'b0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL enc_timeout: got timeout required completion"); end
    n_tests++; if (busy_first !== 1'b1) begin n_fail++; $display("FAIL enc_busy_rise: got %b required 1", busy_first); end
    n_tests++; if (first_lat != 1) begin n_fail++; $display("FAIL enc_latency: got %0d required 1", first_lat); end
    e = seq_errs(1'b1);
    n_tests++; if (e != 0) begin n_fail++; $display("FAIL enc_sequence: got %0d bad entries required 0", e); end
    if (got_key.size() == 11) begin
      n_tests++; if (got_key[1] !== FIPS_R1) begin n_fail++; $display("FAIL enc_round1: got %h required %h", got_key[1], FIPS_R1); end
      n_tests++; if (got_key[10] !== FIPS_R10) begin n_fail++; $display("FAIL enc_round10: got %h required %h", got_key[10], FIPS_R10); end
    end
    n_tests++; if (last_hs_cyc - first_lat != 10) begin n_fail++; $display("FAIL enc_back_to_back: got span %0d required 10", last_hs_cyc - first_lat); end
    n_tests++; if (busy_after !== 1'b0 || valid_after !== 1'b0) begin n_fail++; $display("FAIL enc_done: busy %b valid %b required 0 0", busy_after, valid_after); end
    n_tests++; if (key_after !== FIPS_R10) begin n_fail++; $display("FAIL enc_key_hold: got %h required %h", key_after, FIPS_R10); end
  endtask

  task automatic test_decrypt_vector();
    int e;
    expand(FIPS_KEY);
    collect(FIPS_KEY, 1'b0, 100, 1'b0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL dec_timeout: got timeout required completion"); end
    n_tests++; if (first_lat != 11) begin n_fail++; $display("FAIL dec_latency: got %0d required 11", first_lat); end
    e = seq_errs(1'b0);
    n_tests++; if (e != 0) begin n_fail++; $display("FAIL dec_sequence: got %0d bad entries required 0", e); end
    if (got_key.size() == 11) begin
      n_tests++; if (got_key[0] !== FIPS_R10 || got_idx[0] != 10) begin n_fail++; $display("FAIL dec_first: got %h idx %0d required %h idx 10", got_key[0], got_idx[0], FIPS_R10); end
      n_tests++; if (got_key[10] !== FIPS_KEY || got_idx[10] != 0 || !got_last[10]) begin n_fail++; $display("FAIL dec_final: got %h idx %0d last %b required %h idx 0 last 1", got_key[10], got_idx[10], got_last[10], FIPS_KEY); end
    end
    n_tests++; if (busy_after !== 1'b0 || key_after !== FIPS_KEY) begin n_fail++; $display("FAIL dec_done: busy %b key %h required 0 %h", busy_after, key_after, FIPS_KEY); end
  endtask

  task automatic test_decrypt_stall();
    int e;
    expand(FIPS_KEY);
    collect(FIPS_KEY, 1'b0, 45, 1'b0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL stall_timeout: got timeout required completion"); end
    e = seq_errs(1'b0);
    n_tests++; if (e != 0) begin n_fail++; $display("FAIL stall_sequence: got %0d bad entries required 0", e); end
    n_tests++; if (stall_bad != 0) begin n_fail++; $display("FAIL stall_stable: got %0d unstable cycles required 0", stall_bad); end
  endtask

  task automatic test_start_ignored();
    logic [127:0] k;
    int           e;
    for (int run = 0; run < 2; run++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k);
      collect(k, run[0], 100, 1'b1);
      e = seq_errs(run[0]);
      n_tests++; if (timed_out || e != 0) begin n_fail++; $display("FAIL start_ignored_seq: got %0d bad entries timeout %b required 0 0", e, timed_out); end
      n_tests++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL start_ignored_busy: got %b required 0", busy_after); end
    end
  endtask

  task automatic test_random_keys();
    logic [127:0] k;
    bit           enc;
    int           e;
    for (int run = 0; run < 4; run++) begin
      k   = {$urandom, $urandom, $urandom, $urandom};
      enc = 1'($urandom_range(0, 1));
      expand(k);
      collect(k, enc, 60, 1'b0);
      e = seq_errs(enc);
      n_tests++; if (timed_out || e != 0 || stall_bad != 0) begin n_fail++; $display("FAIL random_run%0d: bad %0d unstable %0d timeout %b required 0 0 0", run, e, stall_bad, timed_out); end
    end
  endtask

  task automatic test_reset_mid();
    bit           seen;
    logic [127:0] k;
    int           e;
    seen = 0;
    Start = 1'b1; Encrypt = 1'b1; Key = FIPS_KEY; Round_key_ready = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (Round_key_valid && Round_index == 4'd5) seen = 1;
      else tick();
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL midreset_reach5: got no round 5 required round 5"); end
    Rst_n = 1'b0;
    #1;
    n_tests++;
    if (Round_key !== 128'h0 || Round_key_valid !== 1'b0 || Round_index !== 4'd0 || Last !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got key %h valid %b idx %0d last %b busy %b required all 0", Round_key, Round_key_valid, Round_index, Last, Busy);
    end
    Round_key_ready = 1'b0;
    repeat (2) tick();
    Rst_n = 1'b1;
    tick();
    k = {$urandom, $urandom, $urandom, $urandom};
    expand(k);
    collect(k, 1'b1, 100, 1'b0);
    n_tests++; if (first_lat != 1) begin n_fail++; $display("FAIL midreset_restart_lat: got %0d required 1", first_lat); end
    if (got_key.size() > 0) begin
      n_tests++; if (got_key[0] !== k || got_idx[0] != 0) begin n_fail++; $display("FAIL midreset_round0: got %h idx %0d required %h idx 0", got_key[0], got_idx[0], k); end
    end
    e = seq_errs(1'b1);
    n_tests++; if (e != 0) begin n_fail++; $display("FAIL midreset_sequence: got %0d bad entries required 0", e); end
  endtask

  task automatic test_key_cache();
    logic [127:0] k;
    logic [127:0] k2;
    int           hit_lat;
    int           e;
`ifdef AES_KEY_CACHE_EN
    hit_lat = 1;
`else
    hit_lat = 11;
`endif
    k  = {$urandom, $urandom, $urandom, $urandom};
    k2 = k ^ 128'h1;
    expand(k);
    collect(k, 1'b0, 100, 1'b0);
    e = seq_errs(1'b0);
    n_tests++; if (first_lat != 11 || e != 0) begin n_fail++; $display("FAIL cache_first: lat %0d bad %0d required 11 0", first_lat, e); end
    collect(k, 1'b0, 100, 1'b0);
    e = seq_errs(1'b0);
    n_tests++; if (first_lat != hit_lat || e != 0) begin n_fail++; $display("FAIL cache_repeat: lat %0d bad %0d required %0d 0", first_lat, e, hit_lat); end
    expand(k2);
    collect(k2, 1'b0, 100, 1'b0);
    e = seq_errs(1'b0);
    n_tests++; if (first_lat != 11 || e != 0) begin n_fail++; $display("FAIL cache_newkey: lat %0d bad %0d required 11 0", first_lat, e); end
  endtask

  initial begin
    init_sbox();
    test_reset();
    test_encrypt_vector();
    test_decrypt_vector();
    test_decrypt_stall();
    test_start_ignored();
    test_random_keys();
    test_reset_mid();
    test_key_cache();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
